// File: rtl/gpr_file_param.sv
// Parametrised GPR file: optional hardwired zero, write bypass, busy scoreboard
// for multicycle producers, and a valid/ready dump port streaming every register.
module gpr_file_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [WIDTH-1:0]  Rd1,
  output logic [WIDTH-1:0]  Rd2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [WIDTH-1:0]  Wd,
  input  logic              RegWrite,
  input  logic              BusySet,
  input  logic [ADDR_W-1:0] BusyAddr,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              DumpStart,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [WIDTH-1:0]  DumpData,
  output logic              DumpDone
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } dump_state_e;

  logic [WIDTH-1:0]  gpr_q [DEPTH];
  logic [WIDTH-1:0]  gpr_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_en;
  logic              busy_set_en;

  // Writes and busy claims to register 0 are dropped when it is hardwired.
  assign wr_en       = RegWrite && !(ZERO_REG && (A3 == '0));
  assign busy_set_en = BusySet && !(ZERO_REG && (BusyAddr == '0));

  always_comb begin
    gpr_d = gpr_q;
    if (wr_en) gpr_d[A3] = Wd;
  end

  // A new producer claim overrides the completion of the previous one.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)       busy_d[A3]       = 1'b0;
    if (busy_set_en) busy_d[BusyAddr] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (DumpStart) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_STREAM: begin
        if (DumpReady) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) gpr_q[i] <= '0;
      busy_q  <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      gpr_q   <= gpr_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Read ports: stored value, optionally forwarded from a same-cycle write.
  always_comb begin
    Rd1 = gpr_q[A1];
    if (BYPASS && wr_en && (A1 == A3)) Rd1 = Wd;
    if (ZERO_REG && (A1 == '0))        Rd1 = '0;
    Rd2 = gpr_q[A2];
    if (BYPASS && wr_en && (A2 == A3)) Rd2 = Wd;
    if (ZERO_REG && (A2 == '0))        Rd2 = '0;
  end

  assign Busy1 = busy_q[A1];
  assign Busy2 = busy_q[A2];

  assign DumpValid = (state_q == S_STREAM);
  assign DumpDone  = (state_q == S_DONE);
  assign DumpAddr  = idx_q;

  // Dump data follows the same read path as Rd1/Rd2 and is zero outside a beat.
  always_comb begin
    DumpData = gpr_q[idx_q];
    if (BYPASS && wr_en && (idx_q == A3)) DumpData = Wd;
    if (ZERO_REG && (idx_q == '0))        DumpData = '0;
    if (!DumpValid)                       DumpData = '0;
  end

endmodule

// File: tb/tb_gpr_file_param.sv
// Bench for gpr_file_param: directed checks on two parameterisations plus a
// queue-based dump scoreboard drained by an independent monitor.
module tb_gpr_file_param;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  logic        Clk, Reset;
  logic [4:0]  A1, A2, A3, BusyAddr;
  logic [31:0] Wd;
  logic        RegWrite, BusySet, DumpStart, DumpReady;

  logic [31:0] Rd1, Rd2, DumpData;
  logic        Busy1, Busy2, DumpValid, DumpDone;
  logic [4:0]  DumpAddr;

  logic [31:0] nz_rd1, nz_rd2, nz_dump_data;
  logic        nz_busy1, nz_busy2, nz_dump_valid, nz_dump_done;
  logic [4:0]  nz_dump_addr;

  int    n_cmp = 0;
  int    n_err = 0;
  int    beats = 0;
  int    done_cnt = 0;
  bit    mon_en = 0;
  bit    done_exp = 0;
  beat_t exp_q[$];

  gpr_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .Clk(Clk), .Reset(Reset), .A1(A1), .A2(A2), .Rd1(Rd1), .Rd2(Rd2),
    .A3(A3), .Wd(Wd), .RegWrite(RegWrite), .BusySet(BusySet), .BusyAddr(BusyAddr),
    .Busy1(Busy1), .Busy2(Busy2), .DumpStart(DumpStart), .DumpValid(DumpValid),
    .DumpReady(DumpReady), .DumpAddr(DumpAddr), .DumpData(DumpData), .DumpDone(DumpDone)
  );

  gpr_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_nz (
    .Clk(Clk), .Reset(Reset), .A1(A1), .A2(A2), .Rd1(nz_rd1), .Rd2(nz_rd2),
    .A3(A3), .Wd(Wd), .RegWrite(RegWrite), .BusySet(BusySet), .BusyAddr(BusyAddr),
    .Busy1(nz_busy1), .Busy2(nz_busy2), .DumpStart(DumpStart), .DumpValid(nz_dump_valid),
    .DumpReady(DumpReady), .DumpAddr(nz_dump_addr), .DumpData(nz_dump_data),
    .DumpDone(nz_dump_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: DumpDone checked every cycle, beats popped from the scoreboard.
  always @(negedge Clk) begin
    if (mon_en) begin
      check("dump_done", 32'(DumpDone), 32'(done_exp));
      if (DumpDone) done_cnt++;
      done_exp = 1'b0;
      if (DumpValid && DumpReady) begin
        if (exp_q.size() == 0) begin
          check("dump_unexpected_beat", 32'(DumpAddr), 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("dump_addr", 32'(DumpAddr), 32'(e.addr));
          check("dump_data", DumpData, e.data);
          if (e.addr == 5'd31) done_exp = 1'b1;
        end
        beats++;
      end
    end
  end

  task automatic push_dump(input bit scaled);
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      beat_t b;
      b.addr = 5'(i);
      b.data = scaled ? 32'(i * 3) : 32'h0;
      exp_q.push_back(b);
    end
  endtask

  initial begin
    Reset = 1'b1; A1 = '0; A2 = '0; A3 = '0; BusyAddr = '0; Wd = '0;
    RegWrite = 0; BusySet = 0; DumpStart = 0; DumpReady = 0;
    #3;
    check("rst_rd1", Rd1, 32'h0);
    check("rst_rd2", Rd2, 32'h0);
    check("rst_busy1", 32'(Busy1), 32'h0);
    check("rst_busy2", 32'(Busy2), 32'h0);
    check("rst_dvalid", 32'(DumpValid), 32'h0);
    check("rst_ddone", 32'(DumpDone), 32'h0);
    check("rst_daddr", 32'(DumpAddr), 32'h0);
    check("rst_ddata", DumpData, 32'h0);
    tick(); tick();
    #2 Reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // Asynchronous reset between edges clears data and busy immediately
    RegWrite = 1; A3 = 5'd3; Wd = 32'h0000_AAAA; BusySet = 1; BusyAddr = 5'd4;
    tick();
    RegWrite = 0; BusySet = 0; A1 = 5'd3; A2 = 5'd4;
    #2;
    check("pre_rst_rd1", Rd1, 32'h0000_AAAA);
    check("pre_rst_busy2", 32'(Busy2), 32'h1);
    Reset = 1'b1;
    #1;
    check("async_rst_rd1", Rd1, 32'h0);
    check("async_rst_busy2", 32'(Busy2), 32'h0);
    tick();
    #2 Reset = 1'b0;
    tick();

    RegWrite = 1; A3 = 5'd5; Wd = 32'hDEAD_BEEF;
    tick();
    RegWrite = 0; A1 = 5'd5;
    #2 check("r5_read", Rd1, 32'hDEAD_BEEF);

    // Register 0 handling on both parameterisations
    tick();
    A1 = 5'd0; RegWrite = 1; A3 = 5'd0; Wd = 32'hFFFF_FFFF; BusySet = 1; BusyAddr = 5'd0;
    tick();
    RegWrite = 0; BusySet = 0;
    #2;
    check("zero_rd1", Rd1, 32'h0);
    check("zero_busy1", 32'(Busy1), 32'h0);
    check("nz_r0_rd1", nz_rd1, 32'hFFFF_FFFF);
    check("nz_r0_busy1", 32'(nz_busy1), 32'h1);

    // Bypass vs. no bypass
    tick();
    A1 = 5'd7; RegWrite = 1; A3 = 5'd7; Wd = 32'h1234_5678;
    #2;
    check("bypass_rd1", Rd1, 32'h1234_5678);
    check("nobypass_rd1_old", nz_rd1, 32'h0);
    tick();
    RegWrite = 0;
    #2;
    check("bypass_rd1_next", Rd1, 32'h1234_5678);
    check("nobypass_rd1_next", nz_rd1, 32'h1234_5678);

    // Scoreboard set/clear priority
    tick();
    A2 = 5'd9; BusySet = 1; BusyAddr = 5'd9;
    #2 check("busy_not_bypassed", 32'(Busy2), 32'h0);
    tick();
    BusySet = 0;
    #2 check("busy_set", 32'(Busy2), 32'h1);
    tick();
    RegWrite = 1; A3 = 5'd9; Wd = 32'h55; BusySet = 1; BusyAddr = 5'd9;
    tick();
    RegWrite = 0; BusySet = 0;
    #2 check("busy_set_wins", 32'(Busy2), 32'h1);
    tick();
    RegWrite = 1; A3 = 5'd9;
    tick();
    RegWrite = 0;
    #2 check("busy_cleared", 32'(Busy2), 32'h0);

    // Dump with alternating backpressure and an ignored mid-dump start
    tick();
    for (int i = 0; i < 32; i++) begin
      RegWrite = 1; A3 = 5'(i); Wd = 32'(i * 3);
      tick();
    end
    RegWrite = 0;
    push_dump(1'b1);
    beats = 0; done_cnt = 0;
    DumpReady = 1; DumpStart = 1;
    tick();
    DumpStart = 0;
    for (int c = 0; c < 200 && done_cnt == 0; c++) begin
      DumpStart = (c == 20);
      DumpReady = ~DumpReady;
      tick();
    end
    DumpStart = 0; DumpReady = 0;
    check("bp_beats", 32'(beats), 32'd32);
    check("bp_done_cnt", 32'(done_cnt), 32'd1);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("bp_idle_after", 32'(DumpValid), 32'h0);

    // Reset while beat 10 is presented: no DumpDone, dump aborted
    push_dump(1'b1);
    beats = 0; done_cnt = 0;
    DumpReady = 1; DumpStart = 1;
    tick();
    DumpStart = 0;
    for (int c = 0; c < 100 && !(DumpValid && DumpAddr == 5'd10); c++) tick();
    check("reach_beat10", 32'(DumpAddr), 32'd10);
    #2 Reset = 1'b1;
    #1;
    check("midrst_dvalid", 32'(DumpValid), 32'h0);
    check("midrst_daddr", 32'(DumpAddr), 32'h0);
    exp_q.delete();
    tick();
    #2 Reset = 1'b0;
    tick(); tick();
    check("midrst_beats", 32'(beats), 32'd10);
    check("midrst_no_done", 32'(done_cnt), 32'd0);

    // Restart after reset: registers are cleared, stream begins at address 0
    push_dump(1'b0);
    beats = 0; done_cnt = 0;
    DumpReady = 1; DumpStart = 1;
    tick();
    DumpStart = 0;
    for (int c = 0; c < 100 && done_cnt == 0; c++) tick();
    check("restart_beats", 32'(beats), 32'd32);
    check("restart_done_cnt", 32'(done_cnt), 32'd1);
    check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
    DumpReady = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
